// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write signals between the boot host and the loader.
// The host side uses the master modport; the loader uses slave.
interface instr_mem_loader_if #(
  parameter int DEPTH = 64
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              i_start;
  logic              i_byteValid;
  logic [7:0]        i_byte;
  logic              o_byteReady;
  logic              o_wrEn;
  logic [ADDR_W-1:0] o_wrAddr;
  logic [31:0]       o_wrData;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic [31:0]       o_checksum;
  logic              o_cpuRst_n;

  modport master (
    output i_start, i_byteValid, i_byte,
    input  o_byteReady, o_wrEn, o_wrAddr, o_wrData,
    input  o_busy, o_done, o_error, o_checksum, o_cpuRst_n
  );

  modport slave (
    input  i_start, i_byteValid, i_byte,
    output o_byteReady, o_wrEn, o_wrAddr, o_wrData,
    output o_busy, o_done, o_error, o_checksum, o_cpuRst_n
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory writer: header byte N, then 4*N little-endian bytes,
// one write strobe per assembled word; the core stays in reset until the image is complete.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset, waiting for i_start
// S_LEN   | waiting for the header byte (word count, 0 = DEPTH)
// S_DATA  | collecting the four bytes of the current word
// S_WRITE | one-cycle write strobe for the assembled word
// S_DONE  | image complete, core released from reset
// S_ERROR | header exceeded DEPTH, load aborted
module instr_mem_loader #(
  parameter int DEPTH = 64
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  instr_mem_loader_if.slave   bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_9 = 9'(DEPTH);
  localparam logic [7:0] DEPTH_8 = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              ready_q;
  logic [7:0]        len_q;
  logic [7:0]        word_cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       word_lo;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [31:0]       checksum_q;

  logic              accept;
  logic              len_bad;
  logic              last_word;

  assign accept    = bus.i_byteValid & ready_q;
  assign len_bad   = {1'b0, bus.i_byte} > DEPTH_9;
  assign last_word = (word_cnt == (len_q - 8'd1));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // i_start only matters where a load is not already in progress
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.i_start) state_nxt = S_LEN;
      S_LEN:   if (accept) state_nxt = len_bad ? S_ERROR : S_DATA;
      S_DATA:  if (accept && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? S_DONE : S_DATA;
      S_DONE:  if (bus.i_start) state_nxt = S_LEN;
      S_ERROR: if (bus.i_start) state_nxt = S_LEN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ready is registered from the next state so it is high exactly in LEN and DATA
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_nxt == S_LEN) || (state_nxt == S_DATA);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      len_q      <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_lo    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
    end else begin
      if ((state == S_LEN) && accept && !len_bad) begin
        len_q      <= (bus.i_byte == 8'd0) ? DEPTH_8 : bus.i_byte;
        word_cnt   <= '0;
        byte_idx   <= '0;
        checksum_q <= '0;
      end

      if ((state == S_DATA) && accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: word_lo[7:0]   <= bus.i_byte;
          2'd1: word_lo[15:8]  <= bus.i_byte;
          2'd2: word_lo[23:16] <= bus.i_byte;
          default: begin
            wr_addr_q <= word_cnt[ADDR_W-1:0];
            wr_data_q <= {bus.i_byte, word_lo};
          end
        endcase
      end

      if (state == S_WRITE) begin
        checksum_q <= checksum_q ^ wr_data_q;
        if (!last_word) begin
          word_cnt <= word_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.o_byteReady = ready_q;
  assign bus.o_wrEn      = (state == S_WRITE);
  assign bus.o_wrAddr    = wr_addr_q;
  assign bus.o_wrData    = wr_data_q;
  assign bus.o_busy      = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
  assign bus.o_done      = (state == S_DONE);
  assign bus.o_error     = (state == S_ERROR);
  assign bus.o_checksum  = checksum_q;
  assign bus.o_cpuRst_n  = (state == S_DONE);
endmodule
